// File: rtl/jpeg_pkg.sv
// Shared JPEG constants: coefficient/run widths, block size and the zigzag-to-raster
// lookup used by both the encoder ZigZag stage and the decoder's run-length expander.
package jpeg_pkg;

    localparam int unsigned COEF_W   = 8;
    localparam int unsigned RUN_W    = 6;
    localparam int unsigned BLK_SIZE = 64;

    // Entry n is the raster index (row*8+col) of the n-th coefficient in zigzag order.
    localparam logic [5:0] ZZ_TO_RASTER [BLK_SIZE] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/rld_bank.sv
// One 8x8 coefficient bank: 64 registers of COEF_W bits.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (clears every entry)
//   we, waddr      write enable and raster index of the entry to write
//   wdata          coefficient to store
//   clr            synchronous clear of all 64 entries (wins over a write)
//   rd_row         raster row to present on rd_data
//   rd_data        8 coefficients of rd_row, column 0 in the most significant bits
module rld_bank #(
    parameter int unsigned COEF_W = jpeg_pkg::COEF_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [5:0]            waddr,
    input  logic [COEF_W-1:0]     wdata,
    input  logic                  clr,
    input  logic [2:0]            rd_row,
    output logic [8*COEF_W-1:0]   rd_data
);
    import jpeg_pkg::*;

    logic [COEF_W-1:0] mem_q [BLK_SIZE];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLK_SIZE; i++) mem_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < BLK_SIZE; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int c = 0; c < 8; c++) begin
            rd_data[(7-c)*COEF_W +: COEF_W] = mem_q[{rd_row, 3'(c)}];
        end
    end

endmodule

// File: rtl/rld_izigzag.sv
// Run-length decode + inverse zigzag into two ping-pong 8x8 banks, drained one raster
// row per handshake.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   sym_valid/sym_ready             symbol handshake
//   sym_run, sym_level, sym_eob     zero run, signed level, end-of-block marker
//   row_valid/row_ready             row handshake
//   row_data, row_idx, blk_last     raster row (col 0 in MSBs), row number, last-row flag
//   err_run                         sticky: a run pushed past position 63
module rld_izigzag #(
    parameter int unsigned COEF_W = jpeg_pkg::COEF_W,
    parameter int unsigned RUN_W  = jpeg_pkg::RUN_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [RUN_W-1:0]      sym_run,
    input  logic [COEF_W-1:0]     sym_level,
    input  logic                  sym_eob,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [8*COEF_W-1:0]   row_data,
    output logic [2:0]            row_idx,
    output logic                  blk_last,
    output logic                  err_run
);
    import jpeg_pkg::*;

    // Wide enough for pos (<= 63) plus the largest run without wrapping.
    localparam int unsigned SUM_W = ((RUN_W > 6) ? RUN_W : 6) + 1;

    logic [1:0]          full_q, full_d;
    logic                wr_sel_q, rd_sel_q;
    logic [6:0]          pos_q, pos_d;
    logic [2:0]          row_idx_q;
    logic                err_run_q;

    logic                sym_acc, overflow, do_write, blk_close;
    logic                row_acc, blk_release;
    logic [SUM_W-1:0]    sum;
    logic [8*COEF_W-1:0] bank_rows [2];

    assign sym_ready   = ~full_q[wr_sel_q];
    assign sym_acc     = sym_valid & sym_ready;
    assign sum         = SUM_W'(pos_q) + SUM_W'(sym_run);
    assign overflow    = sym_acc & ~sym_eob & (sum > SUM_W'(63));
    assign do_write    = sym_acc & ~sym_eob & ~overflow;
    assign blk_close   = sym_acc & (sym_eob | overflow | (sum == SUM_W'(63)));

    assign row_valid   = full_q[rd_sel_q];
    assign row_acc     = row_valid & row_ready;
    assign blk_release = row_acc & (row_idx_q == 3'd7);

    assign row_data    = bank_rows[rd_sel_q];
    assign row_idx     = row_idx_q;
    assign blk_last    = row_valid & (row_idx_q == 3'd7);
    assign err_run     = err_run_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        rld_bank #(
            .COEF_W (COEF_W)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .we      (do_write & (wr_sel_q == 1'(b))),
            .waddr   (ZZ_TO_RASTER[sum[5:0]]),
            .wdata   (sym_level),
            .clr     (blk_release & (rd_sel_q == 1'(b))),
            .rd_row  (row_idx_q),
            .rd_data (bank_rows[b])
        );
    end

    // Close and release can coincide only on opposite banks: a close needs its bank
    // empty, a release needs its bank full.
    always_comb begin
        full_d = full_q;
        if (blk_close)   full_d[wr_sel_q] = 1'b1;
        if (blk_release) full_d[rd_sel_q] = 1'b0;
    end

    always_comb begin
        pos_d = pos_q;
        if (blk_close)     pos_d = '0;
        else if (do_write) pos_d = 7'(sum) + 7'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            pos_q     <= '0;
            row_idx_q <= '0;
            err_run_q <= 1'b0;
        end else begin
            full_q <= full_d;
            pos_q  <= pos_d;
            if (blk_close) wr_sel_q <= ~wr_sel_q;
            if (blk_release) begin
                rd_sel_q  <= ~rd_sel_q;
                row_idx_q <= '0;
            end else if (row_acc) begin
                row_idx_q <= row_idx_q + 3'd1;
            end
            if (overflow) err_run_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rld_izigzag.sv
// Self-checking bench for rld_izigzag: directed symbol tables, multi-cycle stall and
// reset sequences, and a random run checked through a reference decoder/scoreboard.
module tb_rld_izigzag;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sym_valid = 1'b0;
    logic        sym_ready;
    logic [5:0]  sym_run = '0;
    logic [7:0]  sym_level = '0;
    logic        sym_eob = 1'b0;
    logic        row_valid;
    logic        row_ready;
    logic [63:0] row_data;
    logic [2:0]  row_idx;
    logic        blk_last;
    logic        err_run;

    int checks = 0;
    int errors = 0;

    // row_ready source: 0 always, 1 never, 2 random, 3 manual (rr_manual)
    int   rr_mode = 0;
    logic rr_auto = 1'b1;
    logic rr_manual = 1'b0;
    assign row_ready = (rr_mode == 3) ? rr_manual : rr_auto;

    always #5 clk = ~clk;

    rld_izigzag dut (
        .clk       (clk),
        .reset     (reset),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_run   (sym_run),
        .sym_level (sym_level),
        .sym_eob   (sym_eob),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_idx   (row_idx),
        .blk_last  (blk_last),
        .err_run   (err_run)
    );

    always @(posedge clk) begin
        #1;
        if (rr_mode == 0)      rr_auto = 1'b1;
        else if (rr_mode == 1) rr_auto = 1'b0;
        else                   rr_auto = 1'($urandom_range(0, 1));
    end

    // Reference decoder
    int zz_tab [64] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        logic [63:0] data;
        logic [2:0]  idx;
    } row_t;

    typedef struct {
        logic [5:0] run;
        logic [7:0] lev;
        logic       eob;
        logic       exp_err;
    } vec_t;

    row_t        exp_q [$];
    logic [7:0]  mblk [64];
    int          mpos = 0;
    logic        merr = 1'b0;

    logic [63:0] const_rows [8];
    bit          const_en = 1'b0;
    int          rows_seen = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 64; i++) mblk[i] = 8'h00;
        mpos = 0;
    endfunction

    function automatic void model_close();
        for (int r = 0; r < 8; r++) begin
            row_t e;
            e.data = '0;
            for (int c = 0; c < 8; c++) e.data[(7-c)*8 +: 8] = mblk[r*8+c];
            e.idx = 3'(r);
            exp_q.push_back(e);
        end
        model_clear();
    endfunction

    function automatic void model_accept(input logic [5:0] run, input logic [7:0] lev,
                                         input logic eob);
        int s;
        if (eob) begin
            model_close();
        end else begin
            s = mpos + int'(run);
            if (s > 63) begin
                merr = 1'b1;
                model_close();
            end else begin
                mblk[zz_tab[s]] = lev;
                if (s == 63) model_close();
                else mpos = s + 1;
            end
        end
    endfunction

    // Row monitor: compare every row handshake against the scoreboard.
    always @(negedge clk) begin
        row_t e;
        if (reset && row_valid && row_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL row_unexpected actual=%h required=none", row_data);
            end else begin
                e = exp_q.pop_front();
                chk("row_data", row_data, e.data);
                chk("row_idx", 64'(row_idx), 64'(e.idx));
                chk("blk_last", 64'(blk_last), 64'(e.idx == 3'd7));
            end
            if (const_en && rows_seen < 8) chk("first_block_row", row_data, const_rows[rows_seen]);
            rows_seen++;
        end
    end

    // Drive one symbol and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic send(input logic [5:0] run, input logic [7:0] lev, input logic eob);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        sym_valid = 1'b1;
        sym_run   = run;
        sym_level = lev;
        sym_eob   = eob;
        while (!done) begin
            @(negedge clk);
            if (sym_ready) begin
                model_accept(run, lev, eob);
                done = 1'b1;
            end else if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=stalled required=accepted");
                done = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
        end
        sym_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || row_valid) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(n < 2000), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_row_valid"}, 64'(row_valid), 64'd0);
        chk({tag, "_blk_last"}, 64'(blk_last), 64'd0);
        chk({tag, "_sym_ready"}, 64'(sym_ready), 64'd1);
        chk({tag, "_err_run"}, 64'(err_run), 64'd0);
        chk({tag, "_row_idx"}, 64'(row_idx), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        int   n;
        model_clear();
        for (int i = 0; i < 8; i++) const_rows[i] = 64'h0;
        const_rows[0] = 64'h0500_0000_0000_0000;
        const_rows[1] = 64'hFD00_0000_0000_0000;

        // {run, level, eob, err_run expected after acceptance}
        vecs[0] = '{6'd0,  8'h05, 1'b0, 1'b0};
        vecs[1] = '{6'd1,  8'hFD, 1'b0, 1'b0};
        vecs[2] = '{6'd0,  8'h00, 1'b1, 1'b0};
        vecs[3] = '{6'd63, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{6'd59, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{6'd5,  8'h01, 1'b0, 1'b1};
        vecs[6] = '{6'd2,  8'h09, 1'b0, 1'b1};
        vecs[7] = '{6'd0,  8'h00, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: two-symbol block, full-length run, run overflow.
        const_en = 1'b1;
        rows_seen = 0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].run, vecs[i].lev, vecs[i].eob);
            chk("err_run", 64'(err_run), 64'(vecs[i].exp_err));
            if (i == 2) begin
                chk("close_latency_row_valid", 64'(row_valid), 64'd1);
                chk("close_latency_row_idx", 64'(row_idx), 64'd0);
            end
        end
        wait_drain();
        const_en = 1'b0;

        // 64 symbols, run 0, level = zigzag index; closes on the 64th.
        for (int k = 0; k < 64; k++) begin
            send(6'd0, 8'(k), 1'b0);
            if (k == 62) chk("open_before_64th", 64'(row_valid), 64'd0);
        end
        chk("closed_after_64th", 64'(row_valid), 64'd1);
        wait_drain();
        chk("err_run_sticky", 64'(err_run), 64'(merr));

        // Reader stalled: third block must wait until row 7 of the first hands over.
        rr_mode = 3;
        rr_manual = 1'b0;
        send(6'd0, 8'h01, 1'b0);
        send(6'd0, 8'h00, 1'b1);
        send(6'd2, 8'h02, 1'b0);
        send(6'd0, 8'h00, 1'b1);
        chk("stall_sym_ready_low", 64'(sym_ready), 64'd0);
        chk("stall_row_valid", 64'(row_valid), 64'd1);
        rr_manual = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) begin
                chk("stall_row7_idx", 64'(row_idx), 64'd7);
                chk("stall_ready_before_release", 64'(sym_ready), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        rr_manual = 1'b0;
        chk("stall_ready_after_release", 64'(sym_ready), 64'd1);
        send(6'd1, 8'h03, 1'b0);
        send(6'd0, 8'h00, 1'b1);
        rr_mode = 0;
        wait_drain();

        // Reset during row 3 of a block, then a clean block.
        rr_mode = 3;
        rr_manual = 1'b0;
        send(6'd0, 8'h11, 1'b0);
        send(6'd9, 8'h22, 1'b0);
        send(6'd0, 8'h00, 1'b1);
        rr_manual = 1'b1;
        n = 0;
        while (!(row_valid && row_idx == 3'd3) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_row3", 64'(n < 50), 64'd1);
        reset = 1'b0;
        rr_manual = 1'b0;
        exp_q.delete();
        model_clear();
        merr = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        reset = 1'b1;
        send(6'd3, 8'h44, 1'b0);
        send(6'd0, 8'h00, 1'b1);
        rr_mode = 0;
        wait_drain();

        // Random symbols with stalls on both sides.
        rr_mode = 2;
        for (int b = 0; b < 30; b++) begin
            int nsym;
            nsym = $urandom_range(1, 12);
            for (int s = 0; s < nsym; s++) begin
                logic [5:0] run;
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 9) == 0) run = 6'($urandom_range(0, 63));
                else run = 6'($urandom_range(0, 6));
                send(run, 8'($urandom_range(0, 255)), (s == nsym - 1) ? 1'b1 : 1'b0);
            end
        end
        rr_mode = 0;
        wait_drain();
        chk("random_err_run", 64'(err_run), 64'(merr));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
